// File: rtl/hid2ps2_mod_seq.sv
// hid2ps2_mod_seq
// Turns press/release edges on the translated modifier slot vector into a
// PS/2 Set-2 make/break byte stream. One slot is examined per clock; when a
// slot differs from the last code reported for it, the whole byte sequence
// for that one event is sent before scanning resumes.
//
// Ports
//   clk       system clock
//   reset     asynchronous, active-high reset
//   mod_code  NUM_SLOTS x CODE_W slot vector, slot 0 in the top bits;
//             bit CODE_W-1 of a slot = E0-extended, 0 = released
//   out_data  PS/2 byte presented to the consumer
//   out_valid out_data holds a byte to transfer
//   out_ready consumer accepts the byte (transfer on valid & ready)
//   idle      registered; high while scanning with no pending difference
`timescale 1ns/1ps
module hid2ps2_mod_seq #(
  parameter int NUM_SLOTS = 8,
  parameter int CODE_W    = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLOTS*CODE_W-1:0] mod_code,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        idle
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_SCAN = 2'd0,
    ST_PRE  = 2'd1,
    ST_BRK  = 2'd2,
    ST_CODE = 2'd3
  } state_t;

  state_t              r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [CODE_W-1:0]   r_prev [NUM_SLOTS];
  logic [CODE_W-1:0]   r_job;      // code being reported, ext flag included
  logic                r_brk;      // job is a break
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_idle;

  logic [CODE_W-1:0]   w_slots [NUM_SLOTS];
  logic [CODE_W-1:0]   w_cur;
  logic [CODE_W-1:0]   w_prev_cur;
  logic                w_diff;
  logic                w_xfer;
  logic [SLOT_W-1:0]   w_slot_inc;
  logic [CODE_W-1:0]   w_sel_job;
  logic                w_sel_brk;

  state_t              w_nxt_state;
  logic [SLOT_W-1:0]   w_nxt_slot;
  logic [CODE_W-1:0]   w_nxt_job;
  logic                w_nxt_brk;
  logic [7:0]          w_nxt_data;
  logic                w_nxt_valid;
  logic                w_prev_we;
  logic [CODE_W-1:0]   w_prev_wd;

  // Unpack the flat vector; slot 0 occupies the most significant field.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_slots[i] = mod_code[(NUM_SLOTS-1-i)*CODE_W +: CODE_W];
    end
  end

  assign w_cur      = w_slots[r_slot];
  assign w_prev_cur = r_prev[r_slot];
  assign w_diff     = (w_cur != w_prev_cur);
  assign w_xfer     = r_valid & out_ready;
  assign w_slot_inc = (r_slot == SLOT_W'(NUM_SLOTS-1)) ? {SLOT_W{1'b0}}
                                                       : r_slot + SLOT_W'(1);
  // A reported key must be released first; the new make shows up next pass.
  assign w_sel_brk  = (w_prev_cur != {CODE_W{1'b0}});
  assign w_sel_job  = w_sel_brk ? w_prev_cur : w_cur;

  // Next-state, next-byte and prev-update decode.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_slot  = r_slot;
    w_nxt_job   = r_job;
    w_nxt_brk   = r_brk;
    w_nxt_data  = r_data;
    w_nxt_valid = r_valid;
    w_prev_we   = 1'b0;
    w_prev_wd   = {CODE_W{1'b0}};
    case (r_state)
      ST_SCAN: begin
        if (w_diff) begin
          w_nxt_job   = w_sel_job;
          w_nxt_brk   = w_sel_brk;
          w_nxt_valid = 1'b1;
          if (w_sel_job[CODE_W-1]) begin
            w_nxt_state = ST_PRE;
            w_nxt_data  = 8'hE0;
          end else if (w_sel_brk) begin
            w_nxt_state = ST_BRK;
            w_nxt_data  = 8'hF0;
          end else begin
            w_nxt_state = ST_CODE;
            w_nxt_data  = w_sel_job[7:0];
          end
        end else begin
          w_nxt_slot = w_slot_inc;
        end
      end
      ST_PRE: begin
        if (w_xfer) begin
          if (r_brk) begin
            w_nxt_state = ST_BRK;
            w_nxt_data  = 8'hF0;
          end else begin
            w_nxt_state = ST_CODE;
            w_nxt_data  = r_job[7:0];
          end
        end else begin
          w_nxt_state = ST_PRE;
        end
      end
      ST_BRK: begin
        if (w_xfer) begin
          w_nxt_state = ST_CODE;
          w_nxt_data  = r_job[7:0];
        end else begin
          w_nxt_state = ST_BRK;
        end
      end
      ST_CODE: begin
        // prev only moves once the last byte is gone, so a stall never
        // loses or repeats the event.
        if (w_xfer) begin
          w_prev_we   = 1'b1;
          w_prev_wd   = r_brk ? {CODE_W{1'b0}} : r_job;
          w_nxt_slot  = w_slot_inc;
          w_nxt_state = ST_SCAN;
          w_nxt_valid = 1'b0;
          w_nxt_data  = 8'h00;
        end else begin
          w_nxt_state = ST_CODE;
        end
      end
      default: begin
        w_nxt_state = ST_SCAN;
        w_nxt_valid = 1'b0;
        w_nxt_data  = 8'h00;
      end
    endcase
  end

  // State, job latch, output byte and idle registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
      r_slot  <= {SLOT_W{1'b0}};
      r_job   <= {CODE_W{1'b0}};
      r_brk   <= 1'b0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_idle  <= 1'b1;
    end else begin
      r_state <= w_nxt_state;
      r_slot  <= w_nxt_slot;
      r_job   <= w_nxt_job;
      r_brk   <= w_nxt_brk;
      r_data  <= w_nxt_data;
      r_valid <= w_nxt_valid;
      r_idle  <= (r_state == ST_SCAN) && !w_diff;
    end
  end

  // Per-slot last-reported code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_prev[i] <= {CODE_W{1'b0}};
      end
    end else if (w_prev_we) begin
      r_prev[r_slot] <= w_prev_wd;
    end else begin
      r_prev[r_slot] <= r_prev[r_slot];
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign idle      = r_idle;

endmodule

// File: tb/tb_hid2ps2_mod_seq.sv
`timescale 1ns/1ps
module tb_hid2ps2_mod_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [71:0] mod_code = 72'h0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_lv = 1'b0;
  logic       m_lr = 1'b0;
  logic [7:0] m_ld = 8'h00;

  typedef struct {
    logic [71:0] mod;
    int          n;
    logic [7:0]  b [5];
  } vec_t;

  vec_t vecs [7];

  hid2ps2_mod_seq #(.NUM_SLOTS(8), .CODE_W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .mod_code (mod_code),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] mk(input int slot, input logic [8:0] code);
    logic [71:0] v;
    v = 72'h0;
    v[(7-slot)*9 +: 9] = code;
    return v;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Byte monitor and stall-stability check, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_lv && !m_lr) begin
        chk1("stall_valid", out_valid, 1'b1);
        chk8("stall_data", out_data, m_ld);
      end
      if (out_valid && out_ready) q.push_back(out_data);
    end
    m_lv = out_valid;
    m_lr = out_ready;
    m_ld = out_data;
  end

  // Let the scanner run for a fixed window, then compare collected bytes.
  task automatic drain(input string name, input logic [7:0] eb [5], input int n, input bit toggle);
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      out_ready = toggle ? (i % 3 == 2) : 1'b1;
    end
    out_ready = 1'b1;
    chkn({name, "_count"}, q.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < q.size()) chk8({name, "_byte"}, q[k], eb[k]);
    end
    chk1({name, "_idle"}, idle, 1'b1);
    q.delete();
  endtask

  task automatic do_reset(input logic [71:0] m);
    @(posedge clk); #1;
    reset = 1'b1;
    mod_code = m;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e [5];
    bit got;

    vecs[0] = '{mk(0, 9'h014),                  1, '{8'h14, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[1] = '{mk(0, 9'h014) | mk(3, 9'h11F),  2, '{8'hE0, 8'h1F, 8'h00, 8'h00, 8'h00}};
    vecs[2] = '{mk(0, 9'h014),                  3, '{8'hE0, 8'hF0, 8'h1F, 8'h00, 8'h00}};
    vecs[3] = '{mk(0, 9'h114),                  4, '{8'hF0, 8'h14, 8'hE0, 8'h14, 8'h00}};
    vecs[4] = '{72'h0,                          3, '{8'hE0, 8'hF0, 8'h14, 8'h00, 8'h00}};
    vecs[5] = '{mk(5, 9'h059),                  1, '{8'h59, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{72'h0,                          2, '{8'hF0, 8'h59, 8'h00, 8'h00, 8'h00}};

    // reset values
    repeat (3) @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_data", out_data, 8'h00);
    chk1("rst_idle", idle, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // table-driven single-slot events
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      mod_code = vecs[v].mod;
      drain($sformatf("vec%0d", v), vecs[v].b, vecs[v].n, 1'b0);
    end

    // two slots changing together, scanned from slot 0 after reset
    do_reset(mk(1, 9'h012) | mk(6, 9'h111));
    e = '{8'h12, 8'hE0, 8'h11, 8'h00, 8'h00};
    drain("two_slots", e, 3, 1'b0);
    do_reset(72'h0);

    // extended break under backpressure
    mod_code = mk(4, 9'h114);
    e = '{8'hE0, 8'h14, 8'h00, 8'h00, 8'h00};
    drain("bp_make", e, 2, 1'b0);
    mod_code = 72'h0;
    e = '{8'hE0, 8'hF0, 8'h14, 8'h00, 8'h00};
    drain("bp_break", e, 3, 1'b1);

    // short pulse on slot 2 while stalled on slot 7 is never reported
    out_ready = 1'b0;
    mod_code = mk(7, 9'h127);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk1("busy_valid", got, 1'b1);
    chk8("busy_data", out_data, 8'hE0);
    mod_code = mk(7, 9'h127) | mk(2, 9'h011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mod_code = mk(7, 9'h127);
    e = '{8'hE0, 8'h27, 8'h00, 8'h00, 8'h00};
    drain("pulse", e, 2, 1'b0);
    mod_code = 72'h0;
    e = '{8'hE0, 8'hF0, 8'h27, 8'h00, 8'h00};
    drain("pulse_rel", e, 3, 1'b0);

    // reset after the E0 of an extended make
    mod_code = mk(5, 9'h114);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (q.size() >= 1) begin
        got = 1'b1;
        break;
      end
    end
    chk1("mid_seen", got, 1'b1);
    if (got) chk8("mid_first", q[0], 8'hE0);
    reset = 1'b1;
    #1;
    chk1("mid_valid", out_valid, 1'b0);
    chk8("mid_data", out_data, 8'h00);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    e = '{8'hE0, 8'h14, 8'h00, 8'h00, 8'h00};
    drain("mid_rerun", e, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
